// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: wait-FSM state encodings
// and the resolved per-cycle hazard action.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HC_RUN      = 2'd0,
    HC_MEM_WAIT = 2'd1,
    HC_MD_WAIT  = 2'd2
  } hc_state_e;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_MEM   = 3'd1,
    ACT_MD    = 3'd2,
    ACT_FLUSH = 3'd3,
    ACT_LU    = 3'd4,
    ACT_IF    = 3'd5
  } hc_act_e;

  // Exactly one action per cycle, highest priority first.
  function automatic hc_act_e hc_prioritize(input logic mem_stall, input logic md_stall,
                                            input logic br_taken, input logic lu,
                                            input logic if_stall);
    if (mem_stall)     return ACT_MEM;
    else if (md_stall) return ACT_MD;
    else if (br_taken) return ACT_FLUSH;
    else if (lu)       return ACT_LU;
    else if (if_stall) return ACT_IF;
    else               return ACT_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, branch, memory-wait and mul/div hazards
// into per-stage pause/bubble commands, with a wait watchdog and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             md_busy,
  output logic             pc_pause,
  output logic             if_id_pause,
  output logic             if_id_bubble,
  output logic             id_ex_pause,
  output logic             id_ex_bubble,
  output logic             ex_mem_pause,
  output logic             ex_mem_bubble,
  output logic             mem_wb_pause,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

  logic      mem_stall, md_stall, lu, if_stall;
  hc_act_e   act;
  hc_state_e state, state_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  logic      err_nxt;
  logic      flush_inc;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign md_stall  = md_busy;
  assign lu        = ex_is_load & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign if_stall  = ~imem_ready;
  assign act       = hc_prioritize(mem_stall, md_stall, ex_br_taken, lu, if_stall);

  // Stage commands: a pending branch under a freeze stays visible in EX and is taken later.
  always_comb begin
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_pause   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_pause  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_pause  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset) begin
      pc_pause      = 1'b1;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      unique case (act)
        ACT_MEM: begin
          pc_pause      = 1'b1;
          if_id_pause   = 1'b1;
          id_ex_pause   = 1'b1;
          ex_mem_pause  = 1'b1;
          mem_wb_bubble = 1'b1;
        end
        ACT_MD: begin
          pc_pause      = 1'b1;
          if_id_pause   = 1'b1;
          id_ex_pause   = 1'b1;
          ex_mem_bubble = 1'b1;
        end
        ACT_FLUSH: begin
          if_id_bubble  = 1'b1;
          id_ex_bubble  = 1'b1;
        end
        ACT_LU: begin
          pc_pause      = 1'b1;
          if_id_pause   = 1'b1;
          id_ex_bubble  = 1'b1;
        end
        ACT_IF: begin
          pc_pause      = 1'b1;
          if_id_bubble  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Wait FSM: wcnt counts cycles spent in a wait state, saturating at MAX_WAIT.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_nxt   = err_timeout;
    unique case (state)
      HC_RUN: begin
        if (mem_stall) begin
          state_nxt = HC_MEM_WAIT;
          wcnt_nxt  = WC_W'(1);
        end else if (md_stall) begin
          state_nxt = HC_MD_WAIT;
          wcnt_nxt  = WC_W'(1);
        end
      end
      HC_MEM_WAIT, HC_MD_WAIT: begin
        if (wcnt == WC_MAX)
          err_nxt = 1'b1;
        if ((state == HC_MEM_WAIT) ? dmem_ready : ~md_busy) begin
          state_nxt = HC_RUN;
          wcnt_nxt  = '0;
        end else if (wcnt != WC_MAX) begin
          wcnt_nxt  = wcnt + WC_W'(1);
        end
      end
      default: begin
        state_nxt = HC_RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HC_RUN;
      wcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  assign flush_inc = ex_br_taken & ~mem_stall & ~md_stall;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pc_pause),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus randomized traffic against a
// table-driven behavioural model, compared every cycle on the falling edge.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 6;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_is_load, ex_br_taken, imem_ready, dmem_req, dmem_ready, md_busy;
  logic             pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
  logic             ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             err_timeout;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .md_busy(md_busy),
    .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_bubble(if_id_bubble),
    .id_ex_pause(id_ex_pause), .id_ex_bubble(id_ex_bubble),
    .ex_mem_pause(ex_mem_pause), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_pause(mem_wb_pause), .mem_wb_bubble(mem_wb_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: wait kind (0 none, 1 memory, 2 mul/div), cycles spent waiting, sticky error, counts.
  int     m_mode = 0;
  int     m_age  = 0;
  bit     m_err  = 1'b0;
  longint m_stall = 0;
  longint m_flush = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Order: pc, if_id p/b, id_ex p/b, ex_mem p/b, mem_wb p/b.
  function automatic logic [8:0] dut_vec();
    return {pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
            ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble};
  endfunction

  function automatic logic [8:0] exp_vec();
    bit ms, mds, lu;
    ms  = dmem_req && !dmem_ready;
    mds = md_busy;
    lu  = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (reset)            return 9'b1_01_01_01_01;
    else if (ms)          return 9'b1_10_10_10_01;
    else if (mds)         return 9'b1_10_10_01_00;
    else if (ex_br_taken) return 9'b0_01_01_00_00;
    else if (lu)          return 9'b1_10_01_00_00;
    else if (!imem_ready) return 9'b1_01_00_00_00;
    else                  return 9'b0_00_00_00_00;
  endfunction

  task automatic model_step();
    logic [8:0] ev;
    bit ms;
    if (reset) begin
      m_mode = 0; m_age = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      ev = exp_vec();
      ms = dmem_req && !dmem_ready;
      if (ev[8]) m_stall++;
      if (ex_br_taken && !ms && !md_busy) m_flush++;
      if (m_mode == 0) begin
        m_age = 0;
        if (ms) m_mode = 1;
        else if (md_busy) m_mode = 2;
      end else begin
        m_age++;
        if (m_age >= MAX_WAIT) m_err = 1'b1;
        if ((m_mode == 1 && dmem_ready) || (m_mode == 2 && !md_busy)) m_mode = 0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("outs", 64'(dut_vec()), 64'(exp_vec()));
      check("stall_cnt", 64'(stall_cnt), (m_stall > CMAX) ? CMAX : m_stall);
      check("flush_cnt", 64'(flush_cnt), (m_flush > CMAX) ? CMAX : m_flush);
      check("err_timeout", 64'(err_timeout), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_is_load = 0; ex_br_taken = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 0; md_busy = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    chk_en = 1'b1;

    // Reset drives a full flush.
    @(negedge clock);
    check("rst vec", 64'(dut_vec()), 64'(9'b1_01_01_01_01));
    step();
    reset = 1'b0;

    // Load-use on rs2, then the same with ex_rd=0.
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 3;
    @(negedge clock);
    check("lu vec", 64'(dut_vec()), 64'(9'b1_10_01_00_00));
    step();
    ex_rd = 0; id_rs2 = 0;
    @(negedge clock);
    check("lu x0 vec", 64'(dut_vec()), 64'd0);
    check("lu stall_cnt", 64'(stall_cnt), 64'd1);
    step();

    // Taken branch beats load-use.
    ex_is_load = 1; ex_rd = 7; id_rs1 = 7; ex_br_taken = 1;
    @(negedge clock);
    check("br vec", 64'(dut_vec()), 64'(9'b0_01_01_00_00));
    check("br flush_cnt before", 64'(flush_cnt), 64'd0);
    step();
    idle();
    @(negedge clock);
    check("br flush_cnt after", 64'(flush_cnt), 64'd1);
    step();

    // Three cycles of data-memory wait.
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mem wait bubble", 64'(mem_wb_bubble), 64'd1);
      step();
    end
    dmem_ready = 1;
    @(negedge clock);
    check("mem release bubble", 64'(mem_wb_bubble), 64'd0);
    check("mem stall_cnt", 64'(stall_cnt), 64'd3);
    step();
    idle();

    // Mul/div busy five cycles with a pending branch, flush on the sixth.
    do_reset();
    md_busy = 1; ex_br_taken = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("md ex_mem_bubble", 64'(ex_mem_bubble), 64'd1);
      check("md if_id_bubble", 64'(if_id_bubble), 64'd0);
      step();
    end
    md_busy = 0;
    @(negedge clock);
    check("md flush vec", 64'(dut_vec()), 64'(9'b0_01_01_00_00));
    check("md flush_cnt pre", 64'(flush_cnt), 64'd0);
    step();
    idle();
    @(negedge clock);
    check("md flush_cnt", 64'(flush_cnt), 64'd1);
    step();

    // Watchdog: err sets after MAX_WAIT cycles in the wait state and stays set.
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("timeout", 64'(err_timeout), (c >= 5) ? 64'd1 : 64'd0);
      step();
    end
    idle();
    step();
    step();
    @(negedge clock);
    check("timeout sticky", 64'(err_timeout), 64'd1);

    // Reset in the middle of a mul/div wait.
    md_busy = 1;
    step(); step(); step();
    reset = 1'b1;
    @(negedge clock);
    check("rst in md vec", 64'(dut_vec()), 64'(9'b1_01_01_01_01));
    step();
    reset = 1'b0;
    idle();
    @(negedge clock);
    check("post rst vec", 64'(dut_vec()), 64'd0);
    check("post rst stall_cnt", 64'(stall_cnt), 64'd0);
    check("post rst flush_cnt", 64'(flush_cnt), 64'd0);
    check("post rst err", 64'(err_timeout), 64'd0);
    md_busy = 1;
    for (int i = 0; i < MAX_WAIT; i++) step();
    @(negedge clock);
    check("post rst fresh wait", 64'(err_timeout), 64'd0);
    step();

    // Randomized traffic; small register numbers make load-use matches frequent.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_is_load  = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 3) == 0);
      imem_ready  = ($urandom_range(0, 4) != 0);
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_ready  = ($urandom_range(0, 2) != 0);
      md_busy     = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
